// File: rtl/puzzle_pkg.sv
// puzzle_pkg: shared constants, board layout and FSM states for the puzzle sequencer
package puzzle_pkg;
    localparam logic [1:0] DIR_UP = 2'b00, DIR_DOWN = 2'b01, DIR_LEFT = 2'b10, DIR_RIGHT = 2'b11;
    localparam int BOARD_W = 40, BLANK_LSB = 36, TILE_W = 4, N_TILES = 9;
    localparam int DEPTH_LSB = 30, MOVES_W = 30;
    localparam logic [4:0] REG_INIT = 5'd0, REG_IDEAL = 5'd1, REG_WORK = 5'd2, REG_DIR = 5'd3;
    typedef enum logic [2:0] {IDLE, LOAD, FETCH, STEP, CHECK, DONE} state_t;
endpackage

// File: rtl/puzzle_slide.sv
// puzzle_slide: combinational single slide of the blank with legality check
module puzzle_slide
    import puzzle_pkg::*;
(
    input  logic [BOARD_W-1:0] board,
    input  logic [1:0]         dir,
    output logic [BOARD_W-1:0] next_board,
    output logic               legal
);
    logic [3:0] p, q, tq;
    always_comb begin
        p = board[BOARD_W-1:BLANK_LSB];
        q = dir == DIR_UP ? p - 4'd3 : dir == DIR_DOWN ? p + 4'd3 : dir == DIR_LEFT ? p - 4'd1 : p + 4'd1;
        legal = p > 4'd8 ? 1'b0 :
                dir == DIR_UP   ? p >= 4'd3 :
                dir == DIR_DOWN ? p <= 4'd5 :
                dir == DIR_LEFT ? p % 4'd3 != 4'd0 :
                dir == DIR_RIGHT && p % 4'd3 != 4'd2;
        tq = '0;
        for (int i = 0; i < N_TILES; i++)
            if (q == 4'(i)) tq = board[BLANK_LSB-TILE_W*i-1 -: TILE_W];
        next_board = board;
        if (legal) begin
            next_board[BOARD_W-1:BLANK_LSB] = q;
            for (int i = 0; i < N_TILES; i++) begin
                if (p == 4'(i)) next_board[BLANK_LSB-TILE_W*i-1 -: TILE_W] = tq;
                if (q == 4'(i)) next_board[BLANK_LSB-TILE_W*i-1 -: TILE_W] = '0;
            end
        end
    end
endmodule

// File: rtl/puzzle_sequencer.sv
// puzzle_sequencer: drives the register file to replay slide moves and judge the result
module puzzle_sequencer
    import puzzle_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               solved,
    output logic               illegal,
    output logic [3:0]         fail_step,
    output logic [3:0]         moves_applied,
    output logic [4:0]         rf_src0,
    output logic [4:0]         rf_src1,
    output logic [4:0]         rf_dst,
    output logic               rf_we,
    output logic [BOARD_W-1:0] rf_wdata,
    input  logic [BOARD_W-1:0] rf_rdata0,
    input  logic [BOARD_W-1:0] rf_rdata1
);
    state_t state, nxt;
    logic [MOVES_W-1:0] moves;
    logic [3:0] depth, step;
    logic [BOARD_W-1:0] slid;
    logic legal;

    // moves is shifted left per applied step so the current move is always the top pair
    puzzle_slide u_slide (
        .board      (rf_rdata0),
        .dir        (moves[MOVES_W-1 -: 2]),
        .next_board (slid),
        .legal      (legal)
    );

    assign busy = state != IDLE;
    assign done = state == DONE;

    always_comb begin
        nxt = state;
        rf_src0 = REG_WORK;
        rf_src1 = REG_WORK;
        rf_dst = REG_WORK;
        rf_we = 1'b0;
        rf_wdata = '0;
        case (state)
            IDLE:  nxt = start ? LOAD : IDLE;
            LOAD: begin
                rf_src0 = REG_INIT;
                rf_we = 1'b1;
                rf_wdata = rf_rdata0;
                nxt = FETCH;
            end
            FETCH: begin
                rf_src0 = REG_DIR;
                nxt = rf_rdata0[DEPTH_LSB +: 4] == 4'd0 ? CHECK : STEP;
            end
            STEP: begin
                rf_we = legal;
                rf_wdata = legal ? slid : '0;
                nxt = !legal ? DONE : step + 4'd1 == depth ? CHECK : STEP;
            end
            CHECK: begin
                rf_src1 = REG_IDEAL;
                nxt = DONE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            moves <= '0;
            depth <= '0;
            step <= '0;
            solved <= 1'b0;
            illegal <= 1'b0;
            fail_step <= '0;
            moves_applied <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && start) begin
                solved <= 1'b0;
                illegal <= 1'b0;
                fail_step <= '0;
                moves_applied <= '0;
            end
            if (state == FETCH) begin
                moves <= rf_rdata0[MOVES_W-1:0];
                depth <= rf_rdata0[DEPTH_LSB +: 4];
                step <= '0;
            end
            if (state == STEP && legal) begin
                moves <= moves << 2;
                step <= step + 4'd1;
                moves_applied <= moves_applied + 4'd1;
            end
            if (state == STEP && !legal) begin
                illegal <= 1'b1;
                fail_step <= step;
            end
            if (state == CHECK) solved <= rf_rdata0 == rf_rdata1;
        end
    end
endmodule

// File: tb/tb_puzzle_sequencer.sv
// tb_puzzle_sequencer: directed checks of the sequencer against a behavioural register file
module tb_puzzle_sequencer;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic busy, done, solved, illegal, rf_we;
    logic [3:0] fail_step, moves_applied;
    logic [4:0] rf_src0, rf_src1, rf_dst;
    logic [39:0] rf_wdata, rf_rdata0, rf_rdata1;
    logic [39:0] regs [9];
    logic [39:0] wr_log [$];
    logic [39:0] s_board, s_next;
    logic [1:0] s_dir;
    logic s_legal;
    int errors = 0, checks = 0, lat, nwr;

    always #5 clk = ~clk;

    puzzle_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .solved(solved), .illegal(illegal), .fail_step(fail_step), .moves_applied(moves_applied),
        .rf_src0(rf_src0), .rf_src1(rf_src1), .rf_dst(rf_dst), .rf_we(rf_we),
        .rf_wdata(rf_wdata), .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1)
    );

    puzzle_slide u_slide (.board(s_board), .dir(s_dir), .next_board(s_next), .legal(s_legal));

    assign rf_rdata0 = rf_src0 < 5'd9 ? regs[rf_src0[3:0]] : '0;
    assign rf_rdata1 = rf_src1 < 5'd9 ? regs[rf_src1[3:0]] : '0;

    always @(posedge clk)
        if (rf_we && rf_dst < 5'd9) begin
            regs[rf_dst[3:0]] <= rf_wdata;
            wr_log.push_back(rf_wdata);
        end

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setup(input logic [39:0] init, input logic [39:0] ideal, input logic [39:0] dirw);
        @(negedge clk);
        regs[0] <= init;
        regs[1] <= ideal;
        regs[2] <= '0;
        regs[3] <= dirw;
    endtask

    // extra: cycle offset from acceptance at which start is raised again (0 = never)
    task automatic run(input int extra, output int l, output int n);
        int base;
        base = wr_log.size();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        l = 1;
        while (!done && l < 40) begin
            start = l == extra;
            @(posedge clk); #1;
            l++;
        end
        start = 1'b0;
        n = wr_log.size() - base;
    endtask

    initial begin
        for (int i = 0; i < 9; i++) regs[i] <= '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 40'(busy), 40'd0);
        chk("rst done", 40'(done), 40'd0);
        chk("rst solved", 40'(solved), 40'd0);
        chk("rst illegal", 40'(illegal), 40'd0);
        chk("rst rf_we", 40'(rf_we), 40'd0);
        chk("rst fail_step", 40'(fail_step), 40'd0);
        chk("rst moves_applied", 40'(moves_applied), 40'd0);
        chk("rst rf_dst", 40'(rf_dst), 40'd2);
        rst_n = 1'b1;

        s_board = 40'h5_12345_0786; s_dir = 2'b10; #1;
        chk("slide left legal", 40'(s_legal), 40'd1);
        chk("slide left board", s_next, 40'h4_12340_5786);
        s_dir = 2'b11; #1;
        chk("slide right edge legal", 40'(s_legal), 40'd0);
        chk("slide right edge board", s_next, 40'h5_12345_0786);
        s_board = 40'h0_01234_5678; s_dir = 2'b00; #1;
        chk("slide up top legal", 40'(s_legal), 40'd0);

        setup(40'h5_12345_0786, 40'h8_12345_6780, 40'h00_5000_0000);
        run(0, lat, nwr);
        chk("one latency", 40'(lat), 40'd5);
        chk("one writes", 40'(nwr), 40'd2);
        chk("one load data", wr_log[wr_log.size()-2], 40'h5_12345_0786);
        chk("one step data", wr_log[wr_log.size()-1], 40'h8_12345_6780);
        chk("one solved", 40'(solved), 40'd1);
        chk("one illegal", 40'(illegal), 40'd0);
        chk("one moves", 40'(moves_applied), 40'd1);
        @(posedge clk); #1;
        chk("one done pulse", 40'(done), 40'd0);
        chk("one idle", 40'(busy), 40'd0);

        setup(40'h5_12345_0786, 40'h8_12345_6780, 40'h0);
        run(0, lat, nwr);
        chk("d0 latency", 40'(lat), 40'd4);
        chk("d0 writes", 40'(nwr), 40'd1);
        chk("d0 solved", 40'(solved), 40'd0);
        chk("d0 illegal", 40'(illegal), 40'd0);
        chk("d0 moves", 40'(moves_applied), 40'd0);
        @(posedge clk); #1;
        chk("d0 reg2", regs[2], 40'h5_12345_0786);

        setup(40'h5_12345_0786, 40'h8_12345_6780, 40'h00_8C00_0000);
        run(0, lat, nwr);
        chk("ill latency", 40'(lat), 40'd5);
        chk("ill writes", 40'(nwr), 40'd2);
        chk("ill illegal", 40'(illegal), 40'd1);
        chk("ill solved", 40'(solved), 40'd0);
        chk("ill fail_step", 40'(fail_step), 40'd1);
        chk("ill moves", 40'(moves_applied), 40'd1);
        @(posedge clk); #1;
        chk("ill reg2", regs[2], 40'h2_12045_3786);

        setup(40'h5_12345_0786, 40'h8_12345_6780, 40'h00_C500_0000);
        run(4, lat, nwr);
        chk("busy latency", 40'(lat), 40'd7);
        chk("busy writes", 40'(nwr), 40'd4);
        chk("busy solved", 40'(solved), 40'd1);
        chk("busy moves", 40'(moves_applied), 40'd3);
        repeat (2) @(posedge clk);
        #1;
        chk("busy no requeue", 40'(busy), 40'd0);
        chk("busy reg2", regs[2], 40'h8_12345_6780);

        setup(40'h5_12345_0786, 40'h8_12345_6780, 40'h00_C500_0000);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid in step", 40'(busy), 40'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid busy", 40'(busy), 40'd0);
        chk("mid rf_we", 40'(rf_we), 40'd0);
        chk("mid moves", 40'(moves_applied), 40'd0);
        chk("mid done", 40'(done), 40'd0);
        rst_n = 1'b1;

        setup(40'h9_12345_0786, 40'h8_12345_6780, 40'h00_5000_0000);
        run(0, lat, nwr);
        chk("bad latency", 40'(lat), 40'd4);
        chk("bad writes", 40'(nwr), 40'd1);
        chk("bad illegal", 40'(illegal), 40'd1);
        chk("bad solved", 40'(solved), 40'd0);
        chk("bad fail_step", 40'(fail_step), 40'd0);
        chk("bad moves", 40'(moves_applied), 40'd0);
        @(posedge clk); #1;
        chk("bad reg2", regs[2], 40'h9_12345_0786);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/puzzle_sequencer.md
Name: puzzle_sequencer

Overview:
- Controller that owns the write port and both read ports of the 9-entry, 40-bit puzzle register file.
- On `start`, it copies the initial board into the working register and fetches the slide-direction word.
- It then applies each slide move to the working board, writing the board back after every step.
- Finally it compares the working board against the ideal board and reports solved or illegal-move status to the top level.

Parameters:
- REG_INIT, 0, register index of the initial board.
- REG_IDEAL, 1, register index of the goal board.
- REG_WORK, 2, register index of the working board (scratch).
- REG_DIR, 3, register index of the direction word.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  begin a run; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- solved  out  1  working board equals ideal board; held until the next accepted start.
- illegal  out  1  a move pushed the blank off the grid, or the blank field was > 8; held.
- fail_step  out  4  index of the offending move; 0 if none.
- moves_applied  out  4  count of moves successfully written back.
- rf_src0  out  5  register-file read address 0.
- rf_src1  out  5  register-file read address 1.
- rf_dst  out  5  register-file write address.
- rf_we  out  1  register-file write enable.
- rf_wdata  out  40  register-file write data.
- rf_rdata0  in  40  combinational read data for rf_src0.
- rf_rdata1  in  40  combinational read data for rf_src1.

Behaviour:
- Board format:
  - [39:36] = blank position p (0..8).
  - Tile at grid position i occupies bits [35-4i : 32-4i], row-major order.
- Direction word format:
  - [33:30] = depth d (0..15).
  - Move k occupies bits [29-2k : 28-2k]; k=0 is applied first.
  - Codes: 00 up, 01 down, 10 left, 11 right (direction the blank moves).
- Legality and target position q:
  - up: p>=3, q=p-3.
  - down: p<=5, q=p+3.
  - left: p mod 3 != 0, q=p-1.
  - right: p mod 3 != 2, q=p+1.
  - p>8 is always illegal.
- Slide result: tile[p] <= tile[q], tile[q] <= 0, blank field <= q; all other bits unchanged.
- FSM states: IDLE, LOAD, FETCH, STEP, CHECK, DONE.
  - IDLE: wait for start; on start, clear solved, illegal, fail_step and moves_applied, then go to LOAD.
  - LOAD: rf_src0=REG_INIT, rf_we=1, rf_dst=REG_WORK, rf_wdata=rf_rdata0. Go to FETCH.
  - FETCH: rf_src0=REG_DIR; latch the direction word and depth; zero the step counter. If d=0 go to CHECK, else go to STEP.
  - STEP: rf_src0=REG_WORK; slide result computed combinationally.
    - If legal: rf_we=1, rf_dst=REG_WORK, step+1, moves_applied+1. When step+1==d, go to CHECK.
    - If illegal: rf_we=0, illegal<=1, fail_step<=step, go to DONE.
  - CHECK: rf_src0=REG_WORK, rf_src1=REG_IDEAL; solved <= (rf_rdata0==rf_rdata1). Go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Latency: with start accepted in IDLE at cycle T, a legal run of depth d has done high at T+4+d (d=0 gives T+4).
- rf_we is high only in LOAD and in legal STEP cycles.
- When rf_we=0, idle port defaults are rf_dst=REG_WORK, rf_wdata=0, rf_src0=rf_src1=REG_WORK.
- start is ignored while busy; no queueing.
- Reset, including mid-run: state <= IDLE and all outputs 0 except the idle port defaults. The register-file reset independently restores its contents.
- solved and illegal are mutually exclusive.

Decomposition:
- puzzle_pkg:
  - direction code constants;
  - board field widths and offsets (blank field, 4-bit tile width, 9 tiles);
  - register index constants;
  - FSM state enum.
- Sub-module puzzle_slide: purely combinational.
  - Inputs: board[39:0], dir[1:0].
  - Outputs: next_board[39:0], legal.
  - Unit-tested standalone.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> busy=done=solved=illegal=rf_we=0, fail_step=moves_applied=0.
- Solve in one move:
  - Setup: INIT=0x5_12345_0786 (blank 5), DIR depth 1, move0=01 (down).
  - Required: LOAD writes INIT to reg 2; STEP writes 0x8_12345_6780; solved=1, moves_applied=1, done at T+5.
- Depth 0: pulse start with DIR=0 -> reg 2 = INIT, solved=0, illegal=0, done at T+4, exactly one rf_we pulse.
- Illegal move: DIR depth 2, move0=00 (up, 5->2), move1=11 (right at p=2) -> reg 2 = 0x2_12045_3786, illegal=1, fail_step=1, moves_applied=1, no CHECK.
- Start while busy and reset mid-run:
  - Assert start during STEP -> ignored; run completes unchanged.
  - Assert rst_n=0 during STEP -> next cycle IDLE, busy=0, rf_we=0.
- Corrupt blank: INIT blank field = 9, depth 1 -> illegal=1, fail_step=0, reg 2 not rewritten after LOAD.
